// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store RAM front-end.
package lsu_pkg;

  typedef enum logic [1:0] {
    BYTE    = 2'd0,
    HALF    = 2'd1,
    WORD    = 2'd2,
    ILLEGAL = 2'd3
  } mem_size_e;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LD0  = 3'd1,
    LD1  = 3'd2,
    ST1  = 3'd3,
    RSP  = 3'd4
  } lsu_state_e;

  // Byte-lane mask of an access before it is shifted by the address offset.
  function automatic logic [3:0] size_base_mask(input mem_size_e size);
    case (size)
      BYTE:    return 4'b0001;
      HALF:    return 4'b0011;
      WORD:    return 4'b1111;
      default: return 4'b0000;
    endcase
  endfunction

endpackage

// File: rtl/lsu_ldfmt.sv
// Load formatter: merges two RAM beats, aligns by byte offset, then
// masks to the access size with sign or zero extension.
module lsu_ldfmt
  import lsu_pkg::*;
(
  input  logic [31:0] beat0,
  input  logic [31:0] beat1,
  input  logic [1:0]  off,
  input  mem_size_e   size,
  input  logic        is_unsigned,
  output logic [31:0] rdata
);

  logic [63:0] merged;

  assign merged = {beat1, beat0} >> {off, 3'b000};

  always_comb begin
    rdata = merged[31:0];
    case (size)
      BYTE:    rdata = {{24{~is_unsigned & merged[7]}}, merged[7:0]};
      HALF:    rdata = {{16{~is_unsigned & merged[15]}}, merged[15:0]};
      default: rdata = merged[31:0];
    endcase
  end

endmodule

// File: rtl/lsu_ram_if.sv
// Load/store front-end onto a 32-bit byte-enabled single-port RAM.
// Define LSU_MISALIGNED_EN to split misaligned accesses into two beats.
module lsu_ram_if
  import lsu_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int RAM_ADDR_WIDTH = 10
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic                      req_we,
  input  logic [ADDR_WIDTH-1:0]     req_addr,
  input  logic [1:0]                req_size,
  input  logic                      req_unsigned,
  input  logic [31:0]               req_wdata,
  output logic                      rsp_valid,
  output logic [31:0]               rsp_rdata,
  output logic                      rsp_err,
  output logic                      ram_en,
  output logic [3:0]                ram_we,
  output logic [RAM_ADDR_WIDTH-1:0] ram_addr,
  output logic [31:0]               ram_din,
  input  logic [31:0]               ram_dout
);

`ifdef LSU_MISALIGNED_EN
  localparam bit MISALIGNED_EN = 1'b1;
`else
  localparam bit MISALIGNED_EN = 1'b0;
`endif

  lsu_state_e state_reg, state_next;

  mem_size_e                 size_in;
  logic [1:0]                off_in;
  logic [RAM_ADDR_WIDTH-1:0] word_in;
  logic [7:0]                mask8_in;
  logic [63:0]               wide_in;
  logic                      split_in;
  logic                      illegal_in;
  logic                      accept;

  logic                      we_reg;
  logic [1:0]                off_reg;
  mem_size_e                 size_reg;
  logic                      uns_reg;
  logic [RAM_ADDR_WIDTH-1:0] word_reg;
  logic [31:0]               beat0_reg;
  logic [31:0]               rsp_rdata_reg;
  logic                      rsp_err_reg;
  logic [31:0]               fmt_rdata;
`ifdef LSU_MISALIGNED_EN
  logic                      split_reg;
  logic [3:0]                mask_hi_reg;
  logic [31:0]               din_hi_reg;
`endif

  // Address bits above the RAM range alias and are deliberately dropped.
  logic unused_addr_bits;
  assign unused_addr_bits = ^req_addr[ADDR_WIDTH-1:RAM_ADDR_WIDTH+2];

  assign size_in    = mem_size_e'(req_size);
  assign off_in     = req_addr[1:0];
  assign word_in    = req_addr[RAM_ADDR_WIDTH+1:2];
  assign mask8_in   = {4'b0000, size_base_mask(size_in)} << off_in;
  assign wide_in    = {32'd0, req_wdata} << {off_in, 3'b000};
  assign split_in   = |mask8_in[7:4];
  assign illegal_in = (size_in == ILLEGAL) || (split_in && !MISALIGNED_EN);

  assign req_ready = rst_n && (state_reg == IDLE);
  assign accept    = req_valid && req_ready;
  assign rsp_valid = (state_reg == RSP);
  assign rsp_rdata = rsp_rdata_reg;
  assign rsp_err   = rsp_err_reg;

  lsu_ldfmt u_ldfmt (
    .beat0       ((state_reg == LD1) ? beat0_reg : ram_dout),
    .beat1       (ram_dout),
    .off         (off_reg),
    .size        (size_reg),
    .is_unsigned (uns_reg),
    .rdata       (fmt_rdata)
  );

  always_comb begin
    state_next = state_reg;
    ram_en     = 1'b0;
    ram_we     = 4'b0000;
    ram_addr   = '0;
    ram_din    = '0;
    case (state_reg)
      IDLE: begin
        if (accept) begin
          if (illegal_in) begin
            state_next = RSP;
          end else begin
            // Beat 0 goes straight from the request in the accepting cycle.
            ram_en   = 1'b1;
            ram_addr = word_in;
            ram_we   = req_we ? mask8_in[3:0] : 4'b0000;
            ram_din  = wide_in[31:0];
            if (!req_we)
              state_next = LD0;
`ifdef LSU_MISALIGNED_EN
            else if (split_in)
              state_next = ST1;
`endif
            else
              state_next = RSP;
          end
        end
      end
      LD0: begin
`ifdef LSU_MISALIGNED_EN
        if (split_reg) begin
          ram_en     = 1'b1;
          ram_addr   = word_reg + RAM_ADDR_WIDTH'(1);
          state_next = LD1;
        end else begin
          state_next = RSP;
        end
`else
        state_next = RSP;
`endif
      end
`ifdef LSU_MISALIGNED_EN
      LD1: state_next = RSP;
      ST1: begin
        ram_en     = 1'b1;
        ram_we     = mask_hi_reg;
        ram_addr   = word_reg + RAM_ADDR_WIDTH'(1);
        ram_din    = din_hi_reg;
        state_next = RSP;
      end
`endif
      RSP:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      we_reg        <= 1'b0;
      off_reg       <= 2'b00;
      size_reg      <= BYTE;
      uns_reg       <= 1'b0;
      word_reg      <= '0;
      beat0_reg     <= '0;
      rsp_rdata_reg <= '0;
      rsp_err_reg   <= 1'b0;
`ifdef LSU_MISALIGNED_EN
      split_reg     <= 1'b0;
      mask_hi_reg   <= 4'b0000;
      din_hi_reg    <= '0;
`endif
    end else begin
      state_reg <= state_next;
      if (accept) begin
        we_reg        <= req_we;
        off_reg       <= off_in;
        size_reg      <= size_in;
        uns_reg       <= req_unsigned;
        word_reg      <= word_in;
        rsp_rdata_reg <= '0;
        rsp_err_reg   <= illegal_in;
`ifdef LSU_MISALIGNED_EN
        split_reg     <= split_in;
        mask_hi_reg   <= req_we ? mask8_in[7:4] : 4'b0000;
        din_hi_reg    <= wide_in[63:32];
`endif
      end
      if (state_reg == LD0)
        beat0_reg <= ram_dout;
      if ((state_reg == LD0 && state_next == RSP) || state_reg == LD1)
        rsp_rdata_reg <= we_reg ? 32'd0 : fmt_rdata;
    end
  end

endmodule
